// File: rtl/pkt_pkg.sv
// Shared packet-bus definitions: beat control codes, default widths and
// the arbiter state encoding.
package pkt_pkg;

  localparam int unsigned DEF_DATA_W = 512;
  localparam int unsigned DEF_CTL_W  = 8;
  localparam int unsigned CNT_W      = 16;

  localparam logic [7:0] CTL_INVALID = 8'h00;
  localparam logic [7:0] CTL_START   = 8'h01;
  localparam logic [7:0] CTL_STOP    = 8'h02;
  localparam logic [7:0] CTL_SINGLE  = 8'h03;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/pkt_rr_arbiter_rr_pick.sv
// Combinational round-robin selector: one-hot pick of the first requester
// strictly after index 'last', searching in circular order.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  pick
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = IW'((32'(last) + k) % N);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pkt_rr_arbiter.sv
// Packet-atomic round-robin merge of N_PORTS beat sources onto one bus.
// Optional lock watchdog enabled by defining PKT_ARB_TIMEOUT_EN.
module pkt_rr_arbiter
  import pkt_pkg::*;
#(
  parameter int unsigned N_PORTS = 4,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned CTL_W   = DEF_CTL_W,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_PORTS*DATA_W-1:0] in_data,
  input  logic [N_PORTS*CTL_W-1:0]  in_ctl,
  output logic [N_PORTS-1:0]        in_rdy,
  output logic [DATA_W-1:0]         out_data,
  output logic [CTL_W-1:0]          out_ctl,
  input  logic                      out_rdy,
  output logic [N_PORTS-1:0]        grant,
  output logic                      proto_err,
  output logic [CNT_W-1:0]          pkt_cnt
);

  localparam int unsigned IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1) + 1;

  localparam logic [CTL_W-1:0] C_INVALID = CTL_W'(CTL_INVALID);
  localparam logic [CTL_W-1:0] C_START   = CTL_W'(CTL_START);
  localparam logic [CTL_W-1:0] C_STOP    = CTL_W'(CTL_STOP);
  localparam logic [CTL_W-1:0] C_SINGLE  = CTL_W'(CTL_SINGLE);

  arb_state_e          state;
  logic [IDX_W-1:0]    last;
  logic [N_PORTS-1:0]  req;
  logic [N_PORTS-1:0]  pick;
  logic [N_PORTS-1:0]  lock_oh;
  logic                can_load;
  logic                acc;
  logic                tmo_hit;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [IDX_W-1:0]    sel;
  logic [CTL_W-1:0]    sel_ctl;
  logic [DATA_W-1:0]   sel_data;

  // Only start/stop/single codes count as requests; everything else is idle.
  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      req[i] = (in_ctl[i*CTL_W +: CTL_W] == C_START) ||
               (in_ctl[i*CTL_W +: CTL_W] == C_STOP)  ||
               (in_ctl[i*CTL_W +: CTL_W] == C_SINGLE);
    end
  end

  rr_pick #(
    .N  (N_PORTS),
    .IW (IDX_W)
  ) u_pick (
    .req  (req),
    .last (last),
    .pick (pick)
  );

  // While locked, 'last' already holds the locked port.
  always_comb begin
    lock_oh       = '0;
    lock_oh[last] = 1'b1;
  end

  assign can_load = (out_ctl == C_INVALID) | out_rdy;
  assign grant    = reset ? '0 : ((state == LOCK) ? lock_oh : pick);
  assign in_rdy   = grant & req & {N_PORTS{can_load}};
  assign acc      = |in_rdy;

  always_comb begin
    sel      = '0;
    sel_ctl  = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (grant[i]) begin
        sel      = IDX_W'(i);
        sel_ctl  = in_ctl[i*CTL_W +: CTL_W];
        sel_data = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef PKT_ARB_TIMEOUT_EN
  // Idle cycles inside a locked packet; saturates once the limit is reached.
  always_ff @(posedge clk) begin
    if (reset || (state != LOCK) || acc) begin
      tmo_cnt <= '0;
    end else if (!tmo_hit) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end
`else
  assign tmo_cnt = '0;
`endif

  assign tmo_hit = (tmo_cnt >= TMO_W'(TIMEOUT));

  // Arbitration state, output beat register and status counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last      <= IDX_W'(N_PORTS - 1);
      out_data  <= '0;
      out_ctl   <= C_INVALID;
      proto_err <= 1'b0;
      pkt_cnt   <= '0;
    end else if (acc) begin
      case (state)
        IDLE: begin
          last <= sel;
          if (sel_ctl == C_STOP) begin
            out_ctl   <= C_INVALID;
            proto_err <= 1'b1;
          end else begin
            out_data <= sel_data;
            out_ctl  <= sel_ctl;
            if (sel_ctl == C_START) begin
              state <= LOCK;
            end else begin
              pkt_cnt <= pkt_cnt + CNT_W'(1);
            end
          end
        end
        LOCK: begin
          // Any accepted beat closes the packet; a non-stop code is a violation.
          out_data <= sel_data;
          out_ctl  <= C_STOP;
          pkt_cnt  <= pkt_cnt + CNT_W'(1);
          state    <= IDLE;
          if (sel_ctl != C_STOP) begin
            proto_err <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end else if (can_load) begin
      if ((state == LOCK) && tmo_hit) begin
        out_data  <= '0;
        out_ctl   <= C_STOP;
        proto_err <= 1'b1;
        pkt_cnt   <= pkt_cnt + CNT_W'(1);
        state     <= IDLE;
      end else begin
        out_ctl <= C_INVALID;
      end
    end
  end

endmodule

// File: doc/pkt_rr_arbiter.md
Name: pkt_rr_arbiter

Overview:
- Merges N_PORTS packet sources onto one 512-bit packet bus.
- Round-robin arbitration, packet-atomic: a port keeps the grant from its start beat through its stop beat.
- Beat control codes: 0x00 invalid, 0x01 start, 0x02 stop, 0x03 single-beat 64-byte packet.
- Sits between per-port packet generators/parsers and the single downstream match-action pipeline input.

Parameters:
- N_PORTS, 4, number of requesters (2..8).
- DATA_W, 512, beat data width.
- CTL_W, 8, beat control width.
- TIMEOUT, 64, idle-cycle limit inside a locked packet (used only with the optional feature).

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- in_data  input  N_PORTS*DATA_W  per-port beat data; port i in slice [i*DATA_W +: DATA_W]
- in_ctl  input  N_PORTS*CTL_W  per-port beat control code
- in_rdy  output  N_PORTS  beat on port i accepted this cycle when in_rdy[i]=1 and in_ctl[i] is in 0x01..0x03
- out_data  output  DATA_W  registered output beat data
- out_ctl  output  CTL_W  registered output control; 0x00 means no beat
- out_rdy  input  1  downstream accepts the output beat this cycle
- grant  output  N_PORTS  one-hot current or locked port; all zero when no port is selected
- proto_err  output  1  sticky protocol-error flag
- pkt_cnt  output  16  packets forwarded (count of stop and single beats emitted); wraps at 0xFFFF->0

Behaviour:
- Reset: out_data=0, out_ctl=0, in_rdy=0, grant=0, proto_err=0, pkt_cnt=0, state=IDLE, last pointer=N_PORTS-1 (port 0 has first priority). Reset mid-packet drops the packet; no stop beat is emitted.
- Request: req[i] = in_ctl[i] in {0x01,0x02,0x03}. Codes 0x00 and >=0x04 are idle and are never accepted.
- can_load = (out_ctl==0) | out_rdy. Output register loads only when can_load; otherwise it holds its value.
- in_rdy[i] = grant[i] & req[i] & can_load. This path is combinational.
- Latency: an accepted beat appears on out_* in the next cycle.
- IDLE state:
  - grant = first requesting port after the last pointer, in circular order.
  - 0x03 accepted: forward the beat, pkt_cnt+1, last pointer = that port, stay IDLE.
  - 0x01 accepted: forward the beat, go to LOCK on that port.
  - 0x02 accepted: stray stop; discard it (out_ctl loads 0), set proto_err, advance the pointer.
- LOCK state:
  - grant is fixed to the locked port; other ports get in_rdy=0.
  - 0x02 accepted: forward, pkt_cnt+1, last pointer = locked port, go to IDLE.
  - 0x01 or 0x03 accepted: forward the data with out_ctl forced to 0x02, set proto_err, pkt_cnt+1, go to IDLE.
- No beat accepted while can_load=1: out_ctl loads 0x00.
- Arbitration and the state transition complete in the same cycle as acceptance. A new packet may start the cycle after a stop beat.

Optional Feature:
- Macro: PKT_ARB_TIMEOUT_EN.
- Defined: a counter runs in LOCK and increments every cycle with no accepted beat; it clears on any accepted beat.
  - When the counter reaches TIMEOUT and can_load=1, emit a beat with data=0 and ctl=0x02, set proto_err, pkt_cnt+1, go to IDLE.
  - A real stop beat in the same cycle takes precedence and the counter clears.
- Undefined: no counter; LOCK waits indefinitely.

Decomposition:
- Package pkt_pkg:
  - constants CTL_INVALID=8'h00, CTL_START=8'h01, CTL_STOP=8'h02, CTL_SINGLE=8'h03;
  - DATA_W and CTL_W defaults;
  - arbiter state enum {IDLE, LOCK}.
- Sub-module rr_pick: combinational round-robin selector with parameter N.
  - Inputs: req[N], last index. Output: one-hot pick.
  - Reused by other shared-resource arbiters.

Test Plan:
- Ports 0 and 2 each hold a 0x03 beat, out_rdy=1 -> out_ctl 0x03 from port 0, then port 2 on consecutive cycles; pkt_cnt=2; grant 0001 then 0100.
- Port 1 sends 0x01 (0xA), 0x00, 0x02 (0xB); port 3 sends 0x03 (0xC) throughout -> output is 0xA/0x01, idle, 0xB/0x02, then 0xC/0x03; port 3 in_rdy=0 until the stop is accepted.
- out_rdy=0 for 3 cycles mid-packet -> out_data/out_ctl held stable, in_rdy=0, no beat lost or duplicated.
- Port 0 sends 0x02 while IDLE -> in_rdy[0]=1, out_ctl stays 0x00, proto_err=1, pkt_cnt unchanged.
- LOCK on port 2, port 2 sends 0x03 (0xD) -> out beat 0xD with ctl 0x02, proto_err=1, state IDLE; reset asserted mid-packet -> next cycle all outputs 0 and port 0 has priority.
- With PKT_ARB_TIMEOUT_EN and TIMEOUT=64: start beat then 64 idle cycles -> beat data 0 / ctl 0x02 emitted; proto_err=1; pkt_cnt+1.
